// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 / stride-2 max-pool over a raster pixel stream.
// Horizontal pairs are folded on odd columns; even rows park the pair maxima
// in a half-row line buffer, odd rows combine them with the buffered value
// and emit one pooled pixel the cycle after the window's last pixel.
module maxpool2x2_stream #(
   parameter int DATA_WIDTH = 32,
   parameter int CHANNELS   = 1,
   parameter int IMG_WIDTH  = 224,
   parameter int IMG_HEIGHT = 224,
   parameter int SIGNED     = 1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           valid_in,
   input  logic [CHANNELS*DATA_WIDTH-1:0] data_in,
   output logic [CHANNELS*DATA_WIDTH-1:0] data_out,
   output logic                           valid_out,
   output logic                           frame_done
);

   localparam int PW = CHANNELS * DATA_WIDTH;
   localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
   localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
   localparam int LD = IMG_WIDTH / 2;
   localparam int LW = (LD > 1) ? $clog2(LD) : 1;

   // Odd or degenerate frame sizes would leave windows half-filled.
   if ((IMG_WIDTH % 2) != 0 || IMG_WIDTH < 2 ||
       (IMG_HEIGHT % 2) != 0 || IMG_HEIGHT < 2) begin : g_bad_params
      $error("maxpool2x2_stream: IMG_WIDTH/IMG_HEIGHT must be even and >= 2");
   end

   function automatic logic [DATA_WIDTH-1:0] vmax(input logic [DATA_WIDTH-1:0] a,
                                                  input logic [DATA_WIDTH-1:0] b);
      if (SIGNED != 0) return ($signed(a) > $signed(b)) ? a : b;
      else             return (a > b) ? a : b;
   endfunction

   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic [PW-1:0] h_q, h_d;
   logic [PW-1:0] data_out_q, data_out_d;
   logic          valid_out_q, valid_out_d;
   logic          frame_done_q, frame_done_d;

   // Line buffer is deliberately unreset: every entry is written on an even
   // row before the odd row below reads it.
   logic [PW-1:0] lbuf_q [LD];
   logic [LW-1:0] lb_idx;
   logic [PW-1:0] lb_rd;
   logic          lb_we;

   logic [PW-1:0] hmax;
   logic [PW-1:0] pmax;
   logic          col_last, row_last;

   assign lb_idx   = LW'(col_q >> 1);
   assign lb_rd    = lbuf_q[lb_idx];
   assign col_last = (col_q == CW'(IMG_WIDTH - 1));
   assign row_last = (row_q == RW'(IMG_HEIGHT - 1));

   // Per-lane compares: horizontal pair, then pair vs buffered upper row.
   for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
      logic [DATA_WIDTH-1:0] hmax_l;
      assign hmax_l = vmax(h_q[c*DATA_WIDTH +: DATA_WIDTH], data_in[c*DATA_WIDTH +: DATA_WIDTH]);
      assign hmax[c*DATA_WIDTH +: DATA_WIDTH] = hmax_l;
      assign pmax[c*DATA_WIDTH +: DATA_WIDTH] = vmax(lb_rd[c*DATA_WIDTH +: DATA_WIDTH], hmax_l);
   end

   // Next-state: position counters, hold register, output stage.
   always_comb begin
      col_d        = col_q;
      row_d        = row_q;
      h_d          = h_q;
      data_out_d   = data_out_q;
      valid_out_d  = 1'b0;
      frame_done_d = 1'b0;
      lb_we        = 1'b0;
      if (valid_in) begin
         col_d = col_last ? '0 : col_q + CW'(1);
         if (col_last) row_d = row_last ? '0 : row_q + RW'(1);
         if (!col_q[0]) begin
            h_d = data_in;
         end else if (!row_q[0]) begin
            lb_we = 1'b1;
         end else begin
            data_out_d   = pmax;
            valid_out_d  = 1'b1;
            frame_done_d = col_last && row_last;
         end
      end
   end

   // State and registered outputs; reset drops any pending pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         col_q        <= '0;
         row_q        <= '0;
         h_q          <= '0;
         data_out_q   <= '0;
         valid_out_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         h_q          <= h_d;
         data_out_q   <= data_out_d;
         valid_out_q  <= valid_out_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Line buffer write port (even rows only).
   always_ff @(posedge clk) begin
      if (lb_we) lbuf_q[lb_idx] <= hmax;
   end

   assign data_out   = data_out_q;
   assign valid_out  = valid_out_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Bench for maxpool2x2_stream: three 4x4 instances (signed, unsigned,
// 3-lane signed) share one stimulus stream; a frame-image model predicts
// every cycle, and literal window results pin the model.
module tb_maxpool2x2_stream;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid_in;
   logic [31:0] din_a;
   logic [95:0] din_c;
   logic [31:0] do_a, do_b;
   logic [95:0] do_c;
   logic        vo_a, vo_b, vo_c, fd_a, fd_b, fd_c;

   always #5 clk = ~clk;

   maxpool2x2_stream #(.DATA_WIDTH(32), .CHANNELS(1), .IMG_WIDTH(4), .IMG_HEIGHT(4), .SIGNED(1)) u_a (
      .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(din_a),
      .data_out(do_a), .valid_out(vo_a), .frame_done(fd_a));
   maxpool2x2_stream #(.DATA_WIDTH(32), .CHANNELS(1), .IMG_WIDTH(4), .IMG_HEIGHT(4), .SIGNED(0)) u_b (
      .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(din_a),
      .data_out(do_b), .valid_out(vo_b), .frame_done(fd_b));
   maxpool2x2_stream #(.DATA_WIDTH(32), .CHANNELS(3), .IMG_WIDTH(4), .IMG_HEIGHT(4), .SIGNED(1)) u_c (
      .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(din_c),
      .data_out(do_c), .valid_out(vo_c), .frame_done(fd_c));

   int n_chk  = 0;
   int n_pass = 0;
   int n_fd   = 0;
   logic [31:0] q_a[$], q_b[$];
   logic [95:0] q_c[$];

   task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   function automatic logic [31:0] mx(input logic [31:0] a, input logic [31:0] b, input bit sg);
      if (sg) return ($signed(a) > $signed(b)) ? a : b;
      return (a > b) ? a : b;
   endfunction

   function automatic logic [31:0] mx4(input logic [31:0] a, b, c, d, input bit sg);
      return mx(mx(a, b, sg), mx(c, d, sg), sg);
   endfunction

   // ---- model: store the frame as an image, pool each finished window ----
   logic [31:0] img_a [4][4];
   logic [95:0] img_c [4][4];
   int          mr, mc;
   logic        ev, efd;
   logic [31:0] ea, eb;
   logic [95:0] ec;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mr = 0; mc = 0; ev = 0; efd = 0; ea = 0; eb = 0; ec = 0;
      end else begin
         ev = 0; efd = 0;
         if (valid_in) begin
            img_a[mr][mc] = din_a;
            img_c[mr][mc] = din_c;
            if ((mr % 2) == 1 && (mc % 2) == 1) begin
               ev  = 1;
               efd = (mr == 3 && mc == 3);
               ea  = mx4(img_a[mr-1][mc-1], img_a[mr-1][mc], img_a[mr][mc-1], img_a[mr][mc], 1'b1);
               eb  = mx4(img_a[mr-1][mc-1], img_a[mr-1][mc], img_a[mr][mc-1], img_a[mr][mc], 1'b0);
               for (int l = 0; l < 3; l++)
                  ec[l*32 +: 32] = mx4(img_c[mr-1][mc-1][l*32 +: 32], img_c[mr-1][mc][l*32 +: 32],
                                       img_c[mr][mc-1][l*32 +: 32], img_c[mr][mc][l*32 +: 32], 1'b1);
            end
            mc++;
            if (mc == 4) begin
               mc = 0;
               mr = (mr == 3) ? 0 : mr + 1;
            end
         end
      end
   end

   // ---- compare every cycle, just after the active edge ----
   always @(posedge clk) begin
      #1;
      chk("vo_a", vo_a, ev);   chk("fd_a", fd_a, efd);  chk("do_a", do_a, ea);
      chk("vo_b", vo_b, ev);   chk("fd_b", fd_b, efd);  chk("do_b", do_b, eb);
      chk("vo_c", vo_c, ev);   chk("fd_c", fd_c, efd);  chk("do_c", do_c, ec);
      if (vo_a) q_a.push_back(do_a);
      if (vo_b) q_b.push_back(do_b);
      if (vo_c) q_c.push_back(do_c);
      if (fd_a) n_fd++;
   end

   // ---- stimulus ----
   task automatic drive(input logic [31:0] d, input int k);
      @(negedge clk);
      valid_in = 1'b1;
      din_a    = d;
      din_c    = {32'd7, 32'(100 - k), d};
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         valid_in = 1'b0;
      end
   endtask

   task automatic frame_ramp(input bit gaps);
      for (int k = 0; k < 16; k++) begin
         drive(32'(k), k);
         if (gaps) idle($urandom_range(0, 5));
      end
   endtask

   logic [31:0] sdat [16] = '{32'hFFFFFFFF, 32'hFFFFFFF8, 32'h80000000, 32'h00000001,
                              32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002, 32'h00000003,
                              32'd10, 32'd20, 32'd30, 32'd40,
                              32'd50, 32'd60, 32'd70, 32'd80};
   logic [31:0] exp_a1 [8] = '{32'd5, 32'd7, 32'd13, 32'd15, 32'hFFFFFFFF, 32'd3, 32'd60, 32'd80};
   logic [31:0] exp_b1 [8] = '{32'd5, 32'd7, 32'd13, 32'd15, 32'hFFFFFFFF, 32'h80000000, 32'd60, 32'd80};
   logic [31:0] exp_l1 [4] = '{32'd100, 32'd98, 32'd92, 32'd90};

   initial begin
      reset = 1'b1; valid_in = 1'b0; din_a = '0; din_c = '0;
      repeat (3) @(negedge clk);
      chk("rst_do", do_a, 0); chk("rst_vo", vo_a, 0); chk("rst_fd", fd_a, 0);
      reset = 1'b0;

      // ramp frame then signed-data frame, back to back
      frame_ramp(1'b0);
      for (int k = 0; k < 16; k++) drive(sdat[k], k);
      idle(3);
      chk("bb_cnt_a", q_a.size(), 8);
      chk("bb_cnt_b", q_b.size(), 8);
      chk("bb_fd",    n_fd, 2);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("bb_a%0d", i), q_a[i], exp_a1[i]);
         chk($sformatf("bb_b%0d", i), q_b[i], exp_b1[i]);
         chk($sformatf("bb_c0_%0d", i), q_c[i][31:0],  exp_a1[i]);
         chk($sformatf("bb_c1_%0d", i), q_c[i][63:32], exp_l1[i % 4]);
         chk($sformatf("bb_c2_%0d", i), q_c[i][95:64], 32'd7);
      end

      // ramp frame with idle gaps
      q_a.delete(); q_b.delete(); q_c.delete();
      frame_ramp(1'b1);
      idle(3);
      chk("gap_cnt", q_a.size(), 4);
      for (int i = 0; i < 4; i++) chk($sformatf("gap_a%0d", i), q_a[i], exp_a1[i]);

      // reset after 9 pixels, then a clean frame
      for (int k = 0; k < 9; k++) drive(32'(k + 40), k);
      @(negedge clk);
      valid_in = 1'b0; reset = 1'b1;
      q_a.delete(); q_b.delete(); q_c.delete();
      idle(2);
      chk("mrst_do", do_a, 0); chk("mrst_vo", vo_a, 0); chk("mrst_dc", do_c, 0);
      reset = 1'b0;
      frame_ramp(1'b0);
      idle(3);
      chk("mrst_cnt", q_a.size(), 4);
      for (int i = 0; i < 4; i++) chk($sformatf("mrst_a%0d", i), q_a[i], exp_a1[i]);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
